// File: rtl/midi_pkg.sv
// Shared constants for the MIDI byte-stream decoder: FSM encoding,
// channel event types and system / real-time byte codes.
package midi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_D1 = 3'd1,
        ST_WAIT_D2 = 3'd2,
        ST_SYSEX   = 3'd3,
        ST_SKIP    = 3'd4
    } midi_state_e;

    localparam logic [2:0] EV_NOTE_OFF   = 3'd0;
    localparam logic [2:0] EV_NOTE_ON    = 3'd1;
    localparam logic [2:0] EV_POLY_AT    = 3'd2;
    localparam logic [2:0] EV_CC         = 3'd3;
    localparam logic [2:0] EV_PROGRAM    = 3'd4;
    localparam logic [2:0] EV_CHAN_AT    = 3'd5;
    localparam logic [2:0] EV_PITCH_BEND = 3'd6;

    localparam logic [7:0] SYS_FIRST = 8'hF0;
    localparam logic [7:0] SYX_START = 8'hF0;
    localparam logic [7:0] MTC_QF    = 8'hF1;
    localparam logic [7:0] SONG_POS  = 8'hF2;
    localparam logic [7:0] SONG_SEL  = 8'hF3;
    localparam logic [7:0] TUNE_REQ  = 8'hF6;
    localparam logic [7:0] SYX_END   = 8'hF7;
    localparam logic [7:0] RT_FIRST  = 8'hF8;

    function automatic logic is_realtime(input logic [7:0] b);
        return (b >= RT_FIRST);
    endfunction

    function automatic logic is_chan_status(input logic [7:0] b);
        return (b[7] && (b < SYS_FIRST));
    endfunction

    // Program change and channel aftertouch carry a single data byte.
    function automatic logic is_one_data(input logic [2:0] t);
        return ((t == EV_PROGRAM) || (t == EV_CHAN_AT));
    endfunction

endpackage

// File: rtl/midi_byte_sync.sv
// Synchronizes the asynchronous byte-ready strobe and emits a registered
// one-cycle pulse on its rising edge.
module midi_byte_sync #(
    parameter int BYTE_SYNC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic strobe_o
);

    logic [BYTE_SYNC-1:0] sync_q;
    logic [BYTE_SYNC-1:0] fill_q;
    logic                 prev_q;
    logic                 armed_q;
    logic                 strobe_q;
    logic                 sync_last_s;

    assign sync_last_s = sync_q[BYTE_SYNC-1];

    // Arming waits for the chain to hold genuine samples showing a low level,
    // so a strobe already high at reset release never produces a pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            fill_q   <= '0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[BYTE_SYNC-2:0], async_i};
            fill_q   <= {fill_q[BYTE_SYNC-2:0], 1'b1};
            prev_q   <= sync_last_s;
            armed_q  <= armed_q | (fill_q[BYTE_SYNC-1] & ~sync_last_s);
            strobe_q <= armed_q & sync_last_s & ~prev_q;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/midi_msg_decoder.sv
// MIDI byte-stream parser: running status, sysex/system-common skipping,
// real-time pass-through and a single-entry event output register.
module midi_msg_decoder
    import midi_pkg::*;
#(
    parameter int BYTE_SYNC   = 2,
    parameter int VEL0_AS_OFF = 1
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg,
    input  logic       byteready,
    input  logic [7:0] midibyte,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [2:0] ev_type,
    output logic [3:0] ev_chan,
    output logic [6:0] ev_d1,
    output logic [6:0] ev_d2,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       overrun
);

    logic        strobe_s;

    midi_state_e state_q, state_d;
    logic [6:0]  status_q, status_d;
    logic [6:0]  d1_q, d1_d;
    logic [1:0]  skip_q, skip_d;

    logic        complete_s;
    logic [6:0]  cmp_d1_s;
    logic [6:0]  cmp_d2_s;
    logic [2:0]  cmp_type_s;

    logic        ev_valid_q, ev_valid_d;
    logic [2:0]  ev_type_q, ev_type_d;
    logic [3:0]  ev_chan_q, ev_chan_d;
    logic [6:0]  ev_d1_q, ev_d1_d;
    logic [6:0]  ev_d2_q, ev_d2_d;
    logic        rt_valid_q, rt_valid_d;
    logic [7:0]  rt_byte_q, rt_byte_d;
    logic        overrun_q, overrun_d;

    midi_byte_sync #(
        .BYTE_SYNC (BYTE_SYNC)
    ) u_sync (
        .clk_i    (CLOCK_25),
        .rst_i    (reset_reg),
        .async_i  (byteready),
        .strobe_o (strobe_s)
    );

    // Parser next-state: classify the strobed byte and advance the message FSM.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        d1_d       = d1_q;
        skip_d     = skip_q;
        complete_s = 1'b0;
        cmp_d1_s   = d1_q;
        cmp_d2_s   = 7'd0;
        rt_valid_d = 1'b0;
        rt_byte_d  = rt_byte_q;
        if (strobe_s) begin
            if (is_realtime(midibyte)) begin
                rt_valid_d = 1'b1;
                rt_byte_d  = midibyte;
            end else if (is_chan_status(midibyte)) begin
                status_d = midibyte[6:0];
                state_d  = ST_WAIT_D1;
            end else if (midibyte[7]) begin
                status_d = 7'd0;
                skip_d   = 2'd0;
                case (midibyte)
                    SYX_START: state_d = ST_SYSEX;
                    MTC_QF, SONG_SEL: begin
                        skip_d  = 2'd1;
                        state_d = ST_SKIP;
                    end
                    SONG_POS: begin
                        skip_d  = 2'd2;
                        state_d = ST_SKIP;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_WAIT_D1: begin
                        d1_d     = midibyte[6:0];
                        cmp_d1_s = midibyte[6:0];
                        if (is_one_data(status_q[6:4])) begin
                            complete_s = 1'b1;
                        end else begin
                            state_d = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        complete_s = 1'b1;
                        cmp_d2_s   = midibyte[6:0];
                        state_d    = ST_WAIT_D1;
                    end
                    ST_SKIP: begin
                        if (skip_q <= 2'd1) begin
                            skip_d  = 2'd0;
                            state_d = ST_IDLE;
                        end else begin
                            skip_d = skip_q - 2'd1;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Velocity-0 note-on is folded into note-off when enabled.
    always_comb begin
        cmp_type_s = status_q[6:4];
        if ((VEL0_AS_OFF != 0) && (status_q[6:4] == EV_NOTE_ON) && (cmp_d2_s == 7'd0)) begin
            cmp_type_s = EV_NOTE_OFF;
        end else begin
            cmp_type_s = status_q[6:4];
        end
    end

    // Output register: load on completion unless a held event blocks it.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_type_d  = ev_type_q;
        ev_chan_d  = ev_chan_q;
        ev_d1_d    = ev_d1_q;
        ev_d2_d    = ev_d2_q;
        overrun_d  = overrun_q;
        if (complete_s) begin
            if (!ev_valid_q || ev_ready) begin
                ev_valid_d = 1'b1;
                ev_type_d  = cmp_type_s;
                ev_chan_d  = status_q[3:0];
                ev_d1_d    = cmp_d1_s;
                ev_d2_d    = cmp_d2_s;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end else begin
            ev_valid_d = ev_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLOCK_25) begin
        if (reset_reg) begin
            state_q    <= ST_IDLE;
            status_q   <= 7'd0;
            d1_q       <= 7'd0;
            skip_q     <= 2'd0;
            ev_valid_q <= 1'b0;
            ev_type_q  <= 3'd0;
            ev_chan_q  <= 4'd0;
            ev_d1_q    <= 7'd0;
            ev_d2_q    <= 7'd0;
            rt_valid_q <= 1'b0;
            rt_byte_q  <= 8'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            d1_q       <= d1_d;
            skip_q     <= skip_d;
            ev_valid_q <= ev_valid_d;
            ev_type_q  <= ev_type_d;
            ev_chan_q  <= ev_chan_d;
            ev_d1_q    <= ev_d1_d;
            ev_d2_q    <= ev_d2_d;
            rt_valid_q <= rt_valid_d;
            rt_byte_q  <= rt_byte_d;
            overrun_q  <= overrun_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_type  = ev_type_q;
    assign ev_chan  = ev_chan_q;
    assign ev_d1    = ev_d1_q;
    assign ev_d2    = ev_d2_q;
    assign rt_valid = rt_valid_q;
    assign rt_byte  = rt_byte_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Scoreboard bench for midi_msg_decoder: expected events and real-time bytes
// are queued as bytes are sent and compared when the decoder presents them.
module tb_midi_msg_decoder;

    localparam int BYTE_SYNC = 2;

    logic       CLOCK_25;
    logic       reset_reg;
    logic       byteready;
    logic [7:0] midibyte;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_type;
    logic [3:0] ev_chan;
    logic [6:0] ev_d1;
    logic [6:0] ev_d2;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic       overrun;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] ev_q[$];
    logic [31:0] rt_q[$];

    midi_msg_decoder #(
        .BYTE_SYNC   (BYTE_SYNC),
        .VEL0_AS_OFF (1)
    ) dut (
        .CLOCK_25  (CLOCK_25),
        .reset_reg (reset_reg),
        .byteready (byteready),
        .midibyte  (midibyte),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_type   (ev_type),
        .ev_chan   (ev_chan),
        .ev_d1     (ev_d1),
        .ev_d2     (ev_d2),
        .rt_valid  (rt_valid),
        .rt_byte   (rt_byte),
        .overrun   (overrun)
    );

    initial CLOCK_25 = 1'b0;
    always #5 CLOCK_25 = ~CLOCK_25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_ev(input logic [2:0] t, input logic [3:0] c,
                                          input logic [6:0] d1, input logic [6:0] d2);
        return {11'd0, t, c, d1, d2};
    endfunction

    // Drive one byte; lat reports the cycle (counted from the rising strobe)
    // on which ev_valid was first seen, or 0 if it never rose.
    task automatic send_byte(input logic [7:0] b, output int lat);
        lat = 0;
        @(posedge CLOCK_25);
        #1;
        midibyte  = b;
        byteready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLOCK_25);
            #1;
            if (i == 6) byteready = 1'b0;
            if (ev_valid && lat == 0) lat = i;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int l;
        send_byte(b, l);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge CLOCK_25) begin
        if (ev_valid && ev_ready) begin
            if (ev_q.size() == 0) begin
                chk("ev_unexpected", {11'd0, ev_type, ev_chan, ev_d1, ev_d2}, 32'hFFFF_FFFF);
            end else begin
                chk("ev", {11'd0, ev_type, ev_chan, ev_d1, ev_d2}, ev_q.pop_front());
            end
        end
        if (rt_valid) begin
            if (rt_q.size() == 0) begin
                chk("rt_unexpected", {24'd0, rt_byte}, 32'hFFFF_FFFF);
            end else begin
                chk("rt", {24'd0, rt_byte}, rt_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        reset_reg = 1'b1;
        byteready = 1'b0;
        midibyte  = 8'h00;
        ev_ready  = 1'b1;
        repeat (4) @(posedge CLOCK_25);
        #1;
        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_fields", {11'd0, ev_type, ev_chan, ev_d1, ev_d2}, 32'd0);
        chk("rst_rt", {23'd0, rt_valid, rt_byte}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset_reg = 1'b0;
        repeat (4) @(posedge CLOCK_25);

        // Data byte with no running status is ignored.
        send(8'h40);

        // Note-on with latency measurement on the completing byte.
        send(8'h90);
        send(8'h3C);
        ev_q.push_back(mk_ev(3'd1, 4'd0, 7'h3C, 7'h64));
        send_byte(8'h64, lat);
        chk("ev_latency", lat, BYTE_SYNC + 2);

        // Running status with velocity-0 folded to note-off.
        ev_q.push_back(mk_ev(3'd1, 4'd3, 7'h40, 7'h7F));
        ev_q.push_back(mk_ev(3'd0, 4'd3, 7'h40, 7'h00));
        send(8'h93); send(8'h40); send(8'h7F); send(8'h40); send(8'h00);

        // Real-time byte between data bytes.
        rt_q.push_back(32'h0000_00F8);
        ev_q.push_back(mk_ev(3'd3, 4'd1, 7'h07, 7'h64));
        send(8'hB1); send(8'h07); send(8'hF8); send(8'h64);
        chk("rt_byte_kept", {24'd0, rt_byte}, 32'h0000_00F8);

        // Sysex swallowed, then a one-data-byte program change.
        ev_q.push_back(mk_ev(3'd4, 4'd2, 7'h05, 7'h00));
        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'hC2); send(8'h05);

        // Song position skips two bytes; the third lands in IDLE.
        send(8'hF2); send(8'h01); send(8'h02); send(8'h03);

        // Pitch-bend, then channel aftertouch under running status.
        ev_q.push_back(mk_ev(3'd6, 4'd5, 7'h00, 7'h40));
        send(8'hE5); send(8'h00); send(8'h40);
        ev_q.push_back(mk_ev(3'd5, 4'd7, 7'h22, 7'h00));
        ev_q.push_back(mk_ev(3'd5, 4'd7, 7'h33, 7'h00));
        send(8'hD7); send(8'h22); send(8'h33);
        chk("no_overrun_yet", {31'd0, overrun}, 32'd0);

        // Back-pressure: the second event is dropped and overrun is set.
        ev_ready = 1'b0;
        ev_q.push_back(mk_ev(3'd0, 4'd0, 7'h10, 7'h20));
        send(8'h80); send(8'h10); send(8'h20);
        send(8'h80); send(8'h11); send(8'h20);
        chk("held_valid", {31'd0, ev_valid}, 32'd1);
        chk("held_d1", {25'd0, ev_d1}, 32'h10);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        ev_ready = 1'b1;
        repeat (3) @(posedge CLOCK_25);
        #1;
        chk("valid_cleared", {31'd0, ev_valid}, 32'd0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-message discards the partial note.
        send(8'h90); send(8'h3C);
        @(posedge CLOCK_25);
        #1;
        reset_reg = 1'b1;
        repeat (2) @(posedge CLOCK_25);
        #1;
        reset_reg = 1'b0;
        send(8'h64);
        repeat (4) @(posedge CLOCK_25);
        #1;
        chk("post_rst_valid", {31'd0, ev_valid}, 32'd0);
        chk("post_rst_fields", {11'd0, ev_type, ev_chan, ev_d1, ev_d2}, 32'd0);
        chk("post_rst_rt", {23'd0, rt_valid, rt_byte}, 32'd0);
        chk("post_rst_overrun", {31'd0, overrun}, 32'd0);

        repeat (10) @(posedge CLOCK_25);
        chk("ev_sb_drained", ev_q.size(), 32'd0);
        chk("rt_sb_drained", rt_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
